// File: rtl/pll_clkgen_pkg.sv
// Shared constants, lock-timer state type and phase-point helper for pll_clkgen.
package pll_clkgen_pkg;

   localparam int unsigned DEFAULT_BASE_DIV    = 20;
   localparam int unsigned DEFAULT_LOCK_CYCLES = 64;

   typedef enum logic {
      ST_LOCKING,
      ST_LOCKED
   } lock_state_t;

   typedef struct packed {
      int unsigned quarter;
      int unsigned half;
      int unsigned fifth;
   } phase_points_t;

   // Decode thresholds within one base period of base_div sys_clk cycles.
   function automatic phase_points_t phase_points(input int unsigned base_div);
      phase_points_t pts;
      pts.quarter = base_div / 4;
      pts.half    = base_div / 2;
      pts.fifth   = base_div / 5;
      return pts;
   endfunction

endpackage

// File: rtl/pll_clkgen_if.sv
// Bundle of the generated waveforms and lock flag; master drives, slave observes.
interface pll_clkgen_if;
   logic clk_mul_2;
   logic clk_div;
   logic clk_pha_90;
   logic clk_duc_20;
   logic locked;

   modport master (
      output clk_mul_2,
      output clk_div,
      output clk_pha_90,
      output clk_duc_20,
      output locked
   );

   modport slave (
      input clk_mul_2,
      input clk_div,
      input clk_pha_90,
      input clk_duc_20,
      input locked
   );
endinterface

// File: rtl/pll_lock_timer.sv
// Counts sys_clk edges after reset release and raises locked on the
// LOCK_CYCLES-th one. lock_next is the value locked takes at the coming edge,
// letting the waveform registers start on the same edge as locked.
module pll_lock_timer
   import pll_clkgen_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic locked,
   output logic lock_next
);

   localparam int unsigned CW = $clog2(LOCK_CYCLES + 1);

   lock_state_t   state;
   logic [CW-1:0] cnt;
   logic          last_count;

   // Terminal count and next-state view of locked.
   always_comb begin
      last_count = (cnt == CW'(LOCK_CYCLES - 1));
      lock_next  = !sys_rst && ((state == ST_LOCKED) || last_count);
   end

   // Lock FSM: count while locking, then hold locked until reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state  <= ST_LOCKING;
         cnt    <= '0;
         locked <= 1'b0;
      end else begin
         case (state)
            ST_LOCKING: begin
               if (last_count) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_LOCKED: locked <= 1'b1;
            default: begin
               state  <= ST_LOCKING;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pll_clkgen.sv
// Counter-based stand-in for the board PLL: x2, /2, 90-degree and 20%-duty
// waveforms derived from a base period of BASE_DIV sys_clk cycles.
module pll_clkgen
   import pll_clkgen_pkg::*;
#(
   parameter int unsigned BASE_DIV    = DEFAULT_BASE_DIV,
   parameter int unsigned LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   pll_clkgen_if.master clk_bus
);

   localparam phase_points_t PTS     = phase_points(BASE_DIV);
   localparam int unsigned   PW      = $clog2(BASE_DIV);
   localparam logic [PW-1:0] LAST    = PW'(BASE_DIV - 1);
   localparam logic [PW-1:0] QUARTER = PW'(PTS.quarter);
   localparam logic [PW-1:0] HALF    = PW'(PTS.half);
   localparam logic [PW-1:0] THREE_Q = PW'(PTS.half + PTS.quarter);
   localparam logic [PW-1:0] FIFTH   = PW'(PTS.fifth);

   if ((BASE_DIV % 20) != 0 || BASE_DIV < 20 || LOCK_CYCLES < 1) begin : g_param_check
      $error("pll_clkgen: BASE_DIV must be a nonzero multiple of 20 and LOCK_CYCLES >= 1");
   end

   logic          locked_q;
   logic          lock_next;
   logic [PW-1:0] ph;
   logic [PW-1:0] ph_n;
   logic [PW-1:0] ph_fold;
   logic          div_sel;
   logic          div_n;

   pll_lock_timer #(
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .locked    (locked_q),
      .lock_next (lock_next)
   );

   assign clk_bus.locked = locked_q;

   // Next phase: the first locked cycle starts at ph=0/div_sel=0, then ph
   // wraps at BASE_DIV-1 and toggles div_sel on each wrap.
   always_comb begin
      ph_n  = '0;
      div_n = 1'b0;
      if (locked_q) begin
         if (ph == LAST) begin
            ph_n  = '0;
            div_n = ~div_sel;
         end else begin
            ph_n  = ph + PW'(1);
            div_n = div_sel;
         end
      end
      ph_fold = (ph_n >= HALF) ? (ph_n - HALF) : ph_n;
   end

   // Phase state and registered waveform decode; all zero until lock.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || !lock_next) begin
         ph                 <= '0;
         div_sel            <= 1'b0;
         clk_bus.clk_mul_2  <= 1'b0;
         clk_bus.clk_div    <= 1'b0;
         clk_bus.clk_pha_90 <= 1'b0;
         clk_bus.clk_duc_20 <= 1'b0;
      end else begin
         ph                 <= ph_n;
         div_sel            <= div_n;
         clk_bus.clk_mul_2  <= (ph_fold < QUARTER);
         clk_bus.clk_div    <= ~div_n;
         clk_bus.clk_pha_90 <= (ph_n >= QUARTER) && (ph_n < THREE_Q);
         clk_bus.clk_duc_20 <= (ph_n < FIFTH);
      end
   end

endmodule

// File: tb/tb_pll_clkgen.sv
// Self-checking bench for pll_clkgen: default and BASE_DIV=40/LOCK_CYCLES=1
// instances share clock and reset and are compared every cycle against a
// model computed from edge counts since reset release.
module tb_pll_clkgen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int total = 0;
   int bad   = 0;

   int n_edges = 0;   // edges sampling rst=0 since the last reset edge
   int cyc     = 0;
   int last_duc_rise = -1000;
   logic prev_duc = 1'b0;
   logic prev_pha = 1'b0;
   logic prev_div = 1'b0;

   pll_clkgen_if bus_a ();
   pll_clkgen_if bus_b ();

   pll_clkgen #(
      .BASE_DIV    (20),
      .LOCK_CYCLES (64)
   ) dut_a (
      .sys_clk (clk),
      .sys_rst (rst),
      .clk_bus (bus_a)
   );

   pll_clkgen #(
      .BASE_DIV    (40),
      .LOCK_CYCLES (1)
   ) dut_b (
      .sys_clk (clk),
      .sys_rst (rst),
      .clk_bus (bus_b)
   );

   always #5 clk = ~clk;

   // Expected {locked, mul_2, div, pha_90, duc_20} after n post-release edges.
   function automatic logic [4:0] model(input int n, input int p, input int l);
      int k, ph;
      logic mul, div, pha, duc;
      if (n < l) return 5'b0;
      k   = n - l;
      ph  = k % p;
      mul = (ph % (p / 2)) < (p / 4);
      pha = (ph >= p / 4) && (ph < (3 * p) / 4);
      duc = ph < (p / 5);
      div = ((k / p) % 2) == 0;
      return {1'b1, mul, div, pha, duc};
   endfunction

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      logic [4:0] obs_a, obs_b;
      @(posedge clk);
      if (rst) n_edges = 0;
      else     n_edges++;
      cyc++;
      #1;
      obs_a = {bus_a.locked, bus_a.clk_mul_2, bus_a.clk_div, bus_a.clk_pha_90, bus_a.clk_duc_20};
      obs_b = {bus_b.locked, bus_b.clk_mul_2, bus_b.clk_div, bus_b.clk_pha_90, bus_b.clk_duc_20};
      check("dut_a_p20", obs_a, model(n_edges, 20, 64));
      check("dut_b_p40", obs_b, model(n_edges, 40, 1));
      // Phase relations on the default instance.
      if (bus_a.clk_duc_20 && !prev_duc) last_duc_rise = cyc;
      if (bus_a.clk_pha_90 && !prev_pha)
         check("pha_lag_duc", 5'(cyc - last_duc_rise), 5'd5);
      if (bus_a.clk_div && !prev_div)
         check("div_on_duc_rise", 5'(last_duc_rise == cyc), 5'd1);
      prev_duc = bus_a.clk_duc_20;
      prev_pha = bus_a.clk_pha_90;
      prev_div = bus_a.clk_div;
   endtask

   initial begin
      // Reset hold.
      rst = 1'b1;
      repeat (5) step();
      // Release: 63 unlocked edges, lock on the 64th.
      rst = 1'b0;
      repeat (63) step();
      step();
      check("locked_at_64", {4'b0, bus_a.locked}, 5'd1);
      repeat (36) step();
      // Mid-run reset at k=37.
      rst = 1'b1;
      step();
      check("mid_reset_clear", {bus_a.locked, bus_a.clk_mul_2, bus_a.clk_div,
                                bus_a.clk_pha_90, bus_a.clk_duc_20}, 5'b0);
      rst = 1'b0;
      repeat (64 + 120) step();
      // Randomized run lengths and reset pulses, including resets during locking.
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1, 250)) step();
         rst = 1'b1;
         repeat ($urandom_range(1, 3)) step();
         rst = 1'b0;
      end
      // Long run after lock.
      repeat (64 + 10000) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
